// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//   Round-robin front end that time-shares one combinational ALU among NREQ
//   requesters. A granted request has its opcode and operands registered onto
//   the ALU pins. The ALU result is captured one cycle later and returned on a
//   per-requester response handshake.
//   Optional build macro: ALU_ARB_MOV_BYPASS_EN. When it is defined, an
//   accepted move-b opcode (3'b111) skips EXEC and returns operand b directly.
module alu_share_arbiter #(
  parameter int size = 8,
  parameter int NREQ = 4,
  parameter int OPW  = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*OPW-1:0]    req_op,
  input  logic [NREQ*size-1:0]   req_a,
  input  logic [NREQ*size-1:0]   req_b,
  output logic [OPW-1:0]         alu_sel,
  output logic [size-1:0]        alu_a,
  output logic [size-1:0]        alu_b,
  input  logic [size-1:0]        alu_c,
  output logic [NREQ-1:0]        rsp_valid,
  input  logic [NREQ-1:0]        rsp_ready,
  output logic [size-1:0]        rsp_data
);

  // Width of a requester index.
  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

  // Move-b opcode. It only changes behaviour when the bypass build is enabled.
  localparam logic [OPW-1:0] OP_MOV    = OPW'(3'b111);
  // Requester 0 must be the first one scanned after reset.
  localparam logic [GW-1:0]  LAST_INIT = GW'(NREQ - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_t;

  // Round-robin pick. Returns {found, index}.
  // The scan runs from farthest to nearest so the requester closest after
  // 'last' overwrites any earlier candidate and therefore wins.
  function automatic logic [GW:0] pick_winner(input logic [NREQ-1:0] valid,
                                              input logic [GW-1:0]   last);
    logic [GW:0] res;
    int          idx;
    res = '0;
    for (int i = NREQ; i >= 1; i--) begin
      idx = (int'(last) + i) % NREQ;
      res = valid[idx] ? {1'b1, GW'(idx)} : res;
    end
    return res;
  endfunction

  // One-hot decode of a requester index.
  function automatic logic [NREQ-1:0] onehot(input logic [GW-1:0] id);
    return NREQ'(1) << id;
  endfunction

  state_t              state_r;
  state_t              state_nx_s;
  logic [GW-1:0]       last_grant_r;
  logic [GW-1:0]       gnt_id_r;
  logic [OPW-1:0]      alu_sel_r;
  logic [size-1:0]     alu_a_r;
  logic [size-1:0]     alu_b_r;
  logic [size-1:0]     rsp_data_r;
  logic [NREQ-1:0]     rsp_valid_r;

  logic [GW:0]         pick_s;
  logic                win_found_s;
  logic [GW-1:0]       win_idx_s;
  logic                accept_s;
  logic                bypass_s;
  logic                rsp_done_s;
  logic [NREQ-1:0]     req_ready_s;
  logic [OPW-1:0]      sel_op_s;
  logic [size-1:0]     sel_a_s;
  logic [size-1:0]     sel_b_s;

  // Winner search and operand selection for the current IDLE cycle.
  always_comb begin
    pick_s      = pick_winner(req_valid, last_grant_r);
    win_found_s = pick_s[GW];
    win_idx_s   = pick_s[GW-1:0];
    sel_op_s    = req_op[win_idx_s*OPW +: OPW];
    sel_a_s     = req_a[win_idx_s*size +: size];
    sel_b_s     = req_b[win_idx_s*size +: size];
  end

  // Move-b bypass qualifier. It is constant zero when the feature is not built.
  always_comb begin
`ifdef ALU_ARB_MOV_BYPASS_EN
    bypass_s = (sel_op_s == OP_MOV);
`else
    bypass_s = 1'b0;
`endif
  end

  // Next-state logic and the combinational accept strobe.
  // req_ready is masked while reset is asserted.
  always_comb begin
    state_nx_s  = state_r;
    req_ready_s = '0;
    accept_s    = 1'b0;
    rsp_done_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (rst_n && win_found_s) begin
          req_ready_s = onehot(win_idx_s);
          accept_s    = 1'b1;
          state_nx_s  = bypass_s ? RESP : EXEC;
        end else begin
          state_nx_s  = IDLE;
        end
      end
      EXEC: begin
        state_nx_s = RESP;
      end
      RESP: begin
        if (rsp_ready[gnt_id_r]) begin
          rsp_done_s = 1'b1;
          state_nx_s = IDLE;
        end else begin
          state_nx_s = RESP;
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // State register with synchronous active-low reset.
  // A reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Datapath registers: ALU pins, grant bookkeeping and the response.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant_r <= LAST_INIT;
      gnt_id_r     <= '0;
      alu_sel_r    <= '0;
      alu_a_r      <= '0;
      alu_b_r      <= '0;
      rsp_data_r   <= '0;
      rsp_valid_r  <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            alu_sel_r <= sel_op_s;
            alu_a_r   <= sel_a_s;
            alu_b_r   <= sel_b_s;
            gnt_id_r  <= win_idx_s;
            if (bypass_s) begin
              // Move-b needs no ALU result, so respond on the next cycle.
              rsp_data_r  <= sel_b_s;
              rsp_valid_r <= onehot(win_idx_s);
            end
          end
        end
        EXEC: begin
          // The ALU pins have been stable for a full cycle, so capture the result.
          rsp_data_r  <= alu_c;
          rsp_valid_r <= onehot(gnt_id_r);
        end
        RESP: begin
          if (rsp_done_s) begin
            rsp_valid_r  <= '0;
            last_grant_r <= gnt_id_r;
          end
        end
        default: begin
          rsp_valid_r <= '0;
        end
      endcase
    end
  end

  assign req_ready = req_ready_s;
  assign alu_sel   = alu_sel_r;
  assign alu_a     = alu_a_r;
  assign alu_b     = alu_b_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_data  = rsp_data_r;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed self-checking bench for alu_share_arbiter (4 requesters, 8-bit).
// The bench supplies a small reference ALU: add, sub, and, or, xor, and move-b.
module tb_alu_share_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [11:0] req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [2:0]  alu_sel;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [7:0]  alu_c;
  logic [3:0]  rsp_valid;
  logic [3:0]  rsp_ready;
  logic [7:0]  rsp_data;

  int errors = 0;
  int checks = 0;

  // Expected round-robin results, one per requester.
  logic [7:0] exp_rr [4];
  int         gid  [8];
  int         gcyc [8];
  int         ngr;
  int         cur;

  always #5 clk = ~clk;

  alu_share_arbiter #(.size(8), .NREQ(4), .OPW(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data)
  );

  // Reference ALU driven from the registered pins.
  always_comb begin
    case (alu_sel)
      3'b000:  alu_c = alu_a + alu_b;
      3'b001:  alu_c = alu_a - alu_b;
      3'b010:  alu_c = alu_a & alu_b;
      3'b011:  alu_c = alu_a | alu_b;
      3'b100:  alu_c = alu_a ^ alu_b;
      3'b111:  alu_c = alu_b;
      default: alu_c = 8'h00;
    endcase
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int k, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    req_op[k*3 +: 3] = op;
    req_a[k*8 +: 8]  = a;
    req_b[k*8 +: 8]  = b;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 4'hF;
    rsp_ready = 4'h0;
    req_op    = 12'h000;
    req_a     = 32'h0000_0000;
    req_b     = 32'h0000_0000;

    // 1. Reset held for 2 clocks with all requests valid.
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check_val("rst_req_ready", req_ready, 4'b0000);
    check_val("rst_rsp_valid", rsp_valid, 4'b0000);
    check_val("rst_alu_sel",   alu_sel,   3'b000);
    check_val("rst_alu_a",     alu_a,     8'h00);
    check_val("rst_alu_b",     alu_b,     8'h00);
    check_val("rst_rsp_data",  rsp_data,  8'h00);

    // 2. Single request from requester 2: 0x12 + 0x34 = 0x46.
    next_cycle();
    rst_n     = 1'b1;
    req_valid = 4'b0100;
    rsp_ready = 4'hF;
    set_req(2, 3'b000, 8'h12, 8'h34);
    @(negedge clk);
    check_val("t2_ready", req_ready, 4'b0100);
    next_cycle();
    req_valid = 4'b0000;
    @(negedge clk);
    check_val("t2_exec_valid", rsp_valid, 4'b0000);
    check_val("t2_alu_a", alu_a, 8'h12);
    check_val("t2_alu_b", alu_b, 8'h34);
    check_val("t2_alu_sel", alu_sel, 3'b000);
    next_cycle();
    @(negedge clk);
    check_val("t2_rsp_valid", rsp_valid, 4'b0100);
    check_val("t2_rsp_data", rsp_data, 8'h46);
    next_cycle();

    // 3. Round robin: all requesters valid, responses always accepted.
    rst_n = 1'b0;
    set_req(0, 3'b000, 8'h01, 8'h02); exp_rr[0] = 8'h03;
    set_req(1, 3'b001, 8'h50, 8'h23); exp_rr[1] = 8'h2D;
    set_req(2, 3'b010, 8'hF0, 8'h3C); exp_rr[2] = 8'h30;
    set_req(3, 3'b100, 8'hFF, 8'h0F); exp_rr[3] = 8'hF0;
    next_cycle();
    rst_n     = 1'b1;
    req_valid = 4'hF;
    rsp_ready = 4'hF;
    ngr = 0;
    cur = 0;
    for (int cyc = 0; cyc < 15; cyc++) begin
      @(negedge clk);
      if (req_ready != 4'b0000) begin
        for (int k = 0; k < 4; k++) begin
          if (req_ready[k]) cur = k;
        end
        if (ngr < 8) begin
          gid[ngr]  = cur;
          gcyc[ngr] = cyc;
        end
        ngr++;
      end
      if (rsp_valid != 4'b0000) begin
        check_val("t3_rsp_onehot", rsp_valid, 4'b0001 << cur);
        check_val("t3_rsp_data", rsp_data, exp_rr[cur]);
      end
      next_cycle();
    end
    check_val("t3_grant_count", ngr, 5);
    if (ngr >= 5) begin
      check_val("t3_order0", gid[0], 0);
      check_val("t3_order1", gid[1], 1);
      check_val("t3_order2", gid[2], 2);
      check_val("t3_order3", gid[3], 3);
      check_val("t3_order4", gid[4], 0);
      for (int i = 1; i < 5; i++) begin
        check_val("t3_spacing", gcyc[i] - gcyc[i-1], 3);
      end
    end

    // 4. Backpressure on requester 1 while others keep requesting.
    rst_n     = 1'b0;
    req_valid = 4'b0000;
    next_cycle();
    rst_n     = 1'b1;
    req_valid = 4'b0010;
    rsp_ready = 4'b0000;
    @(negedge clk);
    check_val("t4_ready", req_ready, 4'b0010);
    next_cycle();
    req_valid = 4'hF;
    rsp_ready = 4'b1101;
    @(negedge clk);
    check_val("t4_exec_ready", req_ready, 4'b0000);
    next_cycle();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_val("t4_hold_valid", rsp_valid, 4'b0010);
      check_val("t4_hold_data", rsp_data, 8'h2D);
      check_val("t4_hold_ready", req_ready, 4'b0000);
      next_cycle();
    end
    rsp_ready = 4'hF;
    next_cycle();
    @(negedge clk);
    check_val("t4_release_valid", rsp_valid, 4'b0000);
    check_val("t4_next_grant", req_ready, 4'b0100);

    // 5. Requester 2 is accepted now; reset lands during EXEC.
    next_cycle();
    rst_n = 1'b0;
    @(negedge clk);
    check_val("t5_exec_valid", rsp_valid, 4'b0000);
    next_cycle();
    @(negedge clk);
    check_val("t5_rst_valid", rsp_valid, 4'b0000);
    check_val("t5_rst_alu_a", alu_a, 8'h00);
    check_val("t5_rst_ready", req_ready, 4'b0000);

    // 6. Move-b from requester 0, which must be granted first after reset.
    set_req(0, 3'b111, 8'hAA, 8'h5C);
    next_cycle();
    rst_n     = 1'b1;
    req_valid = 4'hF;
    @(negedge clk);
    check_val("t5_first_grant", req_ready, 4'b0001);
    check_val("t5_no_rsp", rsp_valid, 4'b0000);
    next_cycle();
    req_valid = 4'b0000;
    @(negedge clk);
    check_val("t6_alu_sel", alu_sel, 3'b111);
    check_val("t6_alu_a", alu_a, 8'hAA);
    check_val("t6_alu_b", alu_b, 8'h5C);
`ifdef ALU_ARB_MOV_BYPASS_EN
    check_val("t6_bypass_valid", rsp_valid, 4'b0001);
    check_val("t6_bypass_data", rsp_data, 8'h5C);
    next_cycle();
    @(negedge clk);
    check_val("t6_after_valid", rsp_valid, 4'b0000);
`else
    check_val("t6_exec_valid", rsp_valid, 4'b0000);
    next_cycle();
    @(negedge clk);
    check_val("t6_rsp_valid", rsp_valid, 4'b0001);
    check_val("t6_rsp_data", rsp_data, 8'h5C);
`endif
    next_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
